part_select_accum: RTL and testbench
====================================

Name: part_select_accum

Overview:
- Parametrised register/accumulator that optionally increments each cycle and overwrites a dynamically indexed bit field from a queued field-write request.
- Supports ascending (`+:`) and descending (`-:`) indexed part-select modes per request, with index = base × scale.
- Generalises the fixed 32-bit / 2-bit `-:` counter-update block. Adds a request FIFO, a handshake, clip reporting and synchronous clear.
- Sits in register-file and control-status datapaths as a field-insertion engine.

Parameters:
- WIDTH, 32, accumulator width (≥ FIELD_W).
- FIELD_W, 2, inserted field width (≥ 1).
- BASE_W, 5, request base-index width.
- SCALE_W, 1, request scale width.
- DEPTH, 4, request FIFO depth (power of 2, ≥ 2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cnt_en  in  1  increment accumulator this cycle.
- apply_en  in  1  allow FIFO head to be applied this cycle.
- sync_clr  in  1  synchronous clear and flush.
- req_valid  in  1  field-write request valid.
- req_ready  out  1  request accepted when valid & ready.
- req_desc  in  1  0 = ascending `+:`, 1 = descending `-:`.
- req_base  in  BASE_W  base index (unsigned).
- req_scale  in  SCALE_W  index multiplier (unsigned).
- req_data  in  FIELD_W  field value.
- dout  out  WIDTH  accumulator value (registered).
- clip  out  1  one-cycle pulse: the applied field lost ≥1 bit out of range.
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst_n low, async): dout=0, clip=0, FIFO empty, fifo_count=0. Reset is honoured mid-operation; queued requests are discarded.
- req_ready = (fifo_count < DEPTH) & ~sync_clr. There is no bypass: a pop in the same cycle does not free a slot for a push.
- Push on valid & ready. The entry stores {desc, idx = base*scale (BASE_W+SCALE_W bits, unsigned, no truncation), data}.
- Pop occurs when apply_en & fifo non-empty & ~sync_clr.
- Simultaneous push and pop leaves the count unchanged.
- Latency: a request accepted at edge N is applied at edge N+1 at the earliest.
- Next-state order, evaluated every cycle:
  1. t = cnt_en ? dout+1 (mod 2^WIDTH; all-ones wraps to 0) : dout.
  2. If popping, overwrite the field on t.
  3. Register the result into dout.
- Ascending mode: data[k] → bit idx+k, for k = 0..FIELD_W-1.
- Descending mode: data[FIELD_W-1-k] → bit idx-k, so data MSB lands on bit idx.
- Target bits outside [WIDTH-1:0] (including negative positions) are dropped; the remaining bits are still written.
- If any bit is dropped, clip=1 on the cycle after the pop; otherwise clip=0.
- An idx wholly out of range writes nothing and asserts clip.
- sync_clr has priority over cnt_en, pop and push: next dout=0, FIFO flushed, clip=0.
- No FSM beyond the FIFO pointers. Empty and full are detected by count; pointers wrap mod DEPTH.

Decomposition:
- Package part_sel_pkg:
  - typedef enum ps_mode_e {PS_ASC, PS_DESC};
  - packed struct ps_req_t {mode, idx, data}, parameterised through localparams;
  - function ps_insert(t, req) returning {value, clip}.
- Sub-module ps_req_fifo: synchronous DEPTH-entry FIFO with push, pop, flush, count, full and empty outputs.

Test Plan:
- Reset, then cnt_en=1 for 5 cycles with no requests → dout=5. Preload dout=32'hFFFF_FFFF with cnt_en=1 → dout=0 next cycle, clip=0.
- cnt_en=0, apply_en=1, push desc base=5 scale=1 data=2'b10 → dout=32'h0000_0020 two edges after push, clip=0. Repeat with base=5 scale=0 → effective idx 0, dout bit0=1.
- cnt_en=0, dout=0: push desc base=0 data=2'b11 → dout=32'h1 with clip pulse. Push asc base=31 data=2'b11 → bit31 set, clip=1. With BASE_W=6, push asc base=40 → dout unchanged, clip=1.
- cnt_en=1 and pop in the same cycle with dout=3: asc base=0 data=2'b00 → dout=32'h4 (increment to 4, then bits[1:0] cleared).
- apply_en=0, DEPTH=4: offer 5 requests back-to-back → 4 accepted, req_ready=0, fifo_count=4. Then apply_en=1 → entries applied one per cycle in order, fifo_count drops to 0.
- With 3 entries queued, assert sync_clr alongside req_valid → dout=0, fifo_count=0, request not accepted. Separately, pulse rst_n low mid-stream → outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/part_select_accum_pkg.sv
// Field-insertion types and the bit-merge helper used by the accumulator.
// Widths are fixed maxima here; instances zero-extend into them and truncate back.
package part_sel_pkg;

   localparam int PS_MAX_W     = 64;
   localparam int PS_MAX_FIELD = 16;
   localparam int PS_MAX_IDX   = 24;
   localparam int PS_POS_W     = $clog2(PS_MAX_W);
   localparam int PS_DI_W      = $clog2(PS_MAX_FIELD);

   typedef enum logic {PS_ASC, PS_DESC} ps_mode_e;

   typedef struct packed {
      ps_mode_e                mode;
      logic [PS_MAX_IDX-1:0]   idx;
      logic [PS_MAX_FIELD-1:0] data;
   } ps_req_t;

   typedef struct packed {
      logic [PS_MAX_W-1:0] value;
      logic                clip;
   } ps_ins_t;

   // Bits landing outside [width-1:0], including negative positions, are dropped and flagged.
   function automatic ps_ins_t ps_insert(input logic [PS_MAX_W-1:0] t, input ps_req_t req,
                                         input int width, input int field_w);
      ps_ins_t r;
      int      pos;
      int      di;
      r.value = t;
      r.clip  = 1'b0;
      for (int k = 0; k < PS_MAX_FIELD; k++) begin
         if (k < field_w) begin
            if (req.mode == PS_ASC) begin
               pos = int'(req.idx) + k;
               di  = k;
            end else begin
               pos = int'(req.idx) - k;
               di  = field_w - 1 - k;
            end
            if (pos >= 0 && pos < width)
               r.value[pos[PS_POS_W-1:0]] = req.data[di[PS_DI_W-1:0]];
            else
               r.clip = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/part_select_accum_req_fifo.sv
// Request FIFO: registered pointers, head visible combinationally (0-cycle read).
// Caller must not push when full or pop when empty; flush empties it in one edge.
module ps_req_fifo #(
   parameter  int DW    = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign dout  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/part_select_accum.sv
// Counter/register with queued indexed field writes; a queued write lands one edge after acceptance at the earliest.
// req_ready drops when the FIFO is full or sync_clr is high; apply_en stalls the head.
module part_select_accum
   import part_sel_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int FIELD_W = 2,
   parameter int BASE_W  = 5,
   parameter int SCALE_W = 1,
   parameter int DEPTH   = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cnt_en,
   input  logic                       apply_en,
   input  logic                       sync_clr,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_desc,
   input  logic [BASE_W-1:0]          req_base,
   input  logic [SCALE_W-1:0]         req_scale,
   input  logic [FIELD_W-1:0]         req_data,
   output logic [WIDTH-1:0]           dout,
   output logic                       clip,
   output logic [$clog2(DEPTH):0]     fifo_count
);

   localparam int IDX_W = BASE_W + SCALE_W;
   localparam int DW    = 1 + IDX_W + FIELD_W;

   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [IDX_W-1:0] req_idx;
   logic [DW-1:0]    wr_dat;
   logic [DW-1:0]    rd_dat;
   ps_req_t          head;
   ps_ins_t          ins;
   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] nxt_dout;
   logic             nxt_clip;

   // Index is computed at enqueue so the FIFO holds the full-precision product.
   assign req_idx   = IDX_W'(req_base) * IDX_W'(req_scale);
   assign req_ready = ~full & ~sync_clr;
   assign push      = req_valid & req_ready;
   assign pop       = apply_en & ~empty & ~sync_clr;
   assign wr_dat    = {req_desc, req_idx, req_data};

   ps_req_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (sync_clr),
      .din   (wr_dat),
      .dout  (rd_dat),
      .count (fifo_count),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      head      = '0;
      head.mode = rd_dat[DW-1] ? PS_DESC : PS_ASC;
      head.idx  = PS_MAX_IDX'(rd_dat[FIELD_W +: IDX_W]);
      head.data = PS_MAX_FIELD'(rd_dat[FIELD_W-1:0]);
   end

   // Increment first, then the popped field overwrites the incremented value.
   assign t        = cnt_en ? dout + WIDTH'(1) : dout;
   assign ins      = ps_insert(PS_MAX_W'(t), head, WIDTH, FIELD_W);
   assign nxt_dout = pop ? WIDTH'(ins.value) : t;
   assign nxt_clip = pop & ins.clip;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout <= '0;
         clip <= 1'b0;
      end else if (sync_clr) begin
         dout <= '0;
         clip <= 1'b0;
      end else begin
         dout <= nxt_dout;
         clip <= nxt_clip;
      end
   end

endmodule

// File: tb/tb_part_select_accum.sv
// Directed bench for part_select_accum (BASE_W=6 so out-of-range base indices are reachable).
// Stimulus queues hand-computed expectations; a negedge monitor pops and compares them.
module tb_part_select_accum;

   logic        clk;
   logic        rst_n;
   logic        cnt_en;
   logic        apply_en;
   logic        sync_clr;
   logic        req_valid;
   logic        req_ready;
   logic        req_desc;
   logic [5:0]  req_base;
   logic [0:0]  req_scale;
   logic [1:0]  req_data;
   logic [31:0] dout;
   logic        clip;
   logic [2:0]  fifo_count;

   part_select_accum #(
      .WIDTH(32), .FIELD_W(2), .BASE_W(6), .SCALE_W(1), .DEPTH(4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cnt_en     (cnt_en),
      .apply_en   (apply_en),
      .sync_clr   (sync_clr),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_desc   (req_desc),
      .req_base   (req_base),
      .req_scale  (req_scale),
      .req_data   (req_data),
      .dout       (dout),
      .clip       (clip),
      .fifo_count (fifo_count)
   );

   typedef struct {
      int          cyc;
      string       name;
      bit          c_dout;
      bit          c_clip;
      bit          c_cnt;
      bit          c_rdy;
      logic [31:0] dout;
      logic        clip;
      logic [2:0]  cnt;
      logic        rdy;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   edges    = 0;
   int   checks   = 0;
   int   failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) edges++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic push_exp(input int dly, input string nm, input bit cd, input logic [31:0] d,
                           input bit cc, input logic c, input bit cn, input logic [2:0] n,
                           input bit cr, input logic r);
      exp_t x;
      int   i;
      x.cyc = edges + dly; x.name = nm;
      x.c_dout = cd; x.dout = d; x.c_clip = cc; x.clip = c;
      x.c_cnt = cn; x.cnt = n; x.c_rdy = cr; x.rdy = r;
      i = sb.size();
      while (i > 0 && sb[i-1].cyc > x.cyc) i--;
      sb.insert(i, x);
   endtask

   task automatic exp_out(input int dly, input string nm, input logic [31:0] d, input logic c);
      push_exp(dly, nm, 1, d, 1, c, 0, 3'd0, 0, 1'b0);
   endtask

   task automatic exp_dc(input int dly, input string nm, input logic [31:0] d, input logic c,
                         input logic [2:0] n);
      push_exp(dly, nm, 1, d, 1, c, 1, n, 0, 1'b0);
   endtask

   task automatic exp_fifo(input int dly, input string nm, input logic [2:0] n, input logic r);
      push_exp(dly, nm, 0, 32'd0, 0, 1'b0, 1, n, 1, r);
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= edges) begin
         mon_e = sb.pop_front();
         if (mon_e.cyc < edges) begin
            chk({mon_e.name, "_missed"}, 32'(edges), 32'(mon_e.cyc));
         end else begin
            if (mon_e.c_dout) chk({mon_e.name, "_dout"},  dout,              mon_e.dout);
            if (mon_e.c_clip) chk({mon_e.name, "_clip"},  32'(clip),         32'(mon_e.clip));
            if (mon_e.c_cnt)  chk({mon_e.name, "_count"}, 32'(fifo_count),   32'(mon_e.cnt));
            if (mon_e.c_rdy)  chk({mon_e.name, "_ready"}, 32'(req_ready),    32'(mon_e.rdy));
         end
      end
   end

   task automatic tick(input logic ce, input logic ae, input logic sc, input logic rv,
                       input logic dsc, input logic [5:0] b, input logic s, input logic [1:0] d);
      cnt_en = ce; apply_en = ae; sync_clr = sc; req_valid = rv;
      req_desc = dsc; req_base = b; req_scale = s; req_data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic ce, input logic ae);
      tick(ce, ae, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 2'b00);
   endtask

   task automatic req(input logic ce, input logic ae, input logic dsc, input logic [5:0] b,
                      input logic s, input logic [1:0] d);
      tick(ce, ae, 1'b0, 1'b1, dsc, b, s, d);
   endtask

   task automatic clr();
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 2'b00);
   endtask

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0]  pat  [5];
      logic [31:0] fexp [4];
      pat  = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b11};
      fexp = '{32'h1, 32'h9, 32'h39, 32'h79};

      rst_n = 1'b0;
      cnt_en = 0; apply_en = 0; sync_clr = 0; req_valid = 0;
      req_desc = 0; req_base = '0; req_scale = '0; req_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_dout", dout, 32'd0);
      chk("reset_clip", 32'(clip), 32'd0);
      chk("reset_count", 32'(fifo_count), 32'd0);
      rst_n = 1'b1;

      // Free-running count
      for (int i = 0; i < 5; i++) begin
         if (i == 4) exp_out(1, "cnt5", 32'd5, 1'b0);
         idle(1'b1, 1'b0);
      end

      // Fill every field with ones, then wrap the counter
      for (int j = 0; j < 16; j++) req(1'b0, 1'b1, 1'b0, 6'(2*j), 1'b1, 2'b11);
      exp_out(1, "preload", 32'hFFFF_FFFF, 1'b0);
      idle(1'b0, 1'b1);
      exp_dc(1, "wrap", 32'd0, 1'b0, 3'd0);
      idle(1'b1, 1'b0);

      // Descending writes, in range and with a dropped low bit
      exp_out(2, "desc_b5s1", 32'h20, 1'b0);
      req(1'b0, 1'b1, 1'b1, 6'd5, 1'b1, 2'b10);
      idle(1'b0, 1'b1);
      exp_out(2, "desc_b5s0", 32'h21, 1'b1);
      req(1'b0, 1'b1, 1'b1, 6'd5, 1'b0, 2'b10);
      idle(1'b0, 1'b1);

      exp_dc(1, "clr", 32'd0, 1'b0, 3'd0);
      clr();
      exp_out(2, "desc_b0", 32'h1, 1'b1);
      req(1'b0, 1'b1, 1'b1, 6'd0, 1'b1, 2'b11);
      idle(1'b0, 1'b1);
      exp_out(2, "asc_b31", 32'h8000_0001, 1'b1);
      req(1'b0, 1'b1, 1'b0, 6'd31, 1'b1, 2'b11);
      idle(1'b0, 1'b1);
      exp_out(2, "asc_b40", 32'h8000_0001, 1'b1);
      req(1'b0, 1'b1, 1'b0, 6'd40, 1'b1, 2'b11);
      idle(1'b0, 1'b1);
      exp_out(1, "clip_pulse", 32'h8000_0001, 1'b0);
      idle(1'b0, 1'b1);

      // Increment and pop on the same edge
      clr();
      idle(1'b1, 1'b0);
      idle(1'b1, 1'b0);
      exp_out(1, "pre3", 32'd3, 1'b0);
      req(1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 2'b00);
      exp_dc(1, "inc_pop", 32'd4, 1'b0, 3'd0);
      idle(1'b1, 1'b1);

      // Back-pressure: five offers with apply stalled
      clr();
      for (int i = 0; i < 5; i++) begin
         exp_fifo(0, "fill", 3'(i < 4 ? i : 4), (i < 4));
         req(1'b0, 1'b0, 1'b0, 6'(2*i), 1'b1, pat[i]);
      end
      exp_fifo(0, "full_hold", 3'd4, 1'b0);
      idle(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         exp_dc(1, "drain", fexp[i], 1'b0, 3'(3 - i));
         idle(1'b0, 1'b1);
      end
      exp_dc(1, "fifth_dropped", 32'h79, 1'b0, 3'd0);
      idle(1'b0, 1'b1);

      // sync_clr beats a concurrent request
      for (int i = 0; i < 3; i++) req(1'b0, 1'b0, 1'b0, 6'(10 + 2*i), 1'b1, 2'b11);
      exp_fifo(0, "sclr_rdy", 3'd3, 1'b0);
      exp_dc(1, "sclr", 32'd0, 1'b0, 3'd0);
      tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd20, 1'b1, 2'b11);
      exp_dc(1, "sclr_nopush", 32'd0, 1'b0, 3'd0);
      idle(1'b0, 1'b1);

      // Asynchronous reset mid-stream
      repeat (3) idle(1'b1, 1'b0);
      req(1'b1, 1'b0, 1'b0, 6'd2, 1'b1, 2'b11);
      req(1'b1, 1'b0, 1'b0, 6'd4, 1'b1, 2'b11);
      chk("pre_rst_dout", dout, 32'd5);
      cnt_en = 1'b0; req_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_dout", dout, 32'd0);
      chk("async_rst_clip", 32'(clip), 32'd0);
      chk("async_rst_count", 32'(fifo_count), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      exp_dc(1, "post_rst", 32'd0, 1'b0, 3'd0);
      idle(1'b0, 1'b1);
      idle(1'b0, 1'b0);

      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
